// File: rtl/rst_sequencer_pkg.sv
// rst_seq_pkg: shared state and reset-cause encodings for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_EXT = 2'd1;
    localparam logic [1:0] CAUSE_SW  = 2'd2;

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: request inputs and staged run-enable outputs of the sequencer
interface rst_sequencer_if #(
    parameter int NUM_CH = 3
);

    logic              ext_req;
    logic              sw_req;
    logic [NUM_CH-1:0] user_reset;
    logic              ready;
    logic [1:0]        cause;
    logic              busy;

    modport master (
        output ext_req, sw_req,
        input  user_reset, ready, cause, busy
    );

    modport slave (
        input  ext_req, sw_req,
        output user_reset, ready, cause, busy
    );

endinterface

// File: rtl/rst_filter.sv
// rst_filter: synchronises an async request and accepts it after a run of consecutive high cycles
module rst_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic acc
);

    localparam int FW = $clog2(FILT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [FW-1:0]          cnt;

    // Synchroniser chain and saturating count of consecutive synchronised highs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
            cnt  <= !sync[SYNC_STAGES-1] ? '0 :
                    (cnt == FW'(FILT_CYCLES)) ? cnt : cnt + 1'b1;
        end
    end

    assign acc = cnt >= FW'(FILT_CYCLES);

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: holds all channels after a reset event, then releases them one by one in index order
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int               NUM_CH      = 3,
    parameter int               CNT_W       = 21,
    parameter logic [CNT_W-1:0] POR_CYCLES  = 21'h17D796,
    parameter logic [CNT_W-1:0] SOFT_CYCLES = 21'h00FFFF,
    parameter int               GAP_W       = 12,
    parameter logic [GAP_W-1:0] STAGE_GAP   = 12'd1024,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_CYCLES = 16
) (
    input logic           clk,
    input logic           reset,
    rst_sequencer_if.slave bus
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [GAP_W-1:0]  gap, gap_n;
    logic [IW-1:0]     idx, idx_n, nxt;
    logic [NUM_CH-1:0] ur, ur_n;
    logic              rdy, rdy_n;
    logic [1:0]        cause, cause_n;
    logic              acc;

    rst_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filt (
        .clk  (clk),
        .reset(reset),
        .in   (bus.ext_req),
        .acc  (acc)
    );

    assign nxt = idx + 1'b1;

    // State and output registers; async reset lands in the power-on hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HOLD;
            cnt   <= POR_CYCLES;
            gap   <= '0;
            idx   <= '0;
            ur    <= '0;
            rdy   <= 1'b0;
            cause <= CAUSE_POR;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gap   <= gap_n;
            idx   <= idx_n;
            ur    <= ur_n;
            rdy   <= rdy_n;
            cause <= cause_n;
        end
    end

    // Next state: a reset event overrides everything, otherwise count down the hold then stage releases
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap;
        idx_n   = idx;
        ur_n    = ur;
        rdy_n   = rdy;
        cause_n = cause;
        if (acc || bus.sw_req) begin
            ur_n    = '0;
            rdy_n   = 1'b0;
            cnt_n   = SOFT_CYCLES;
            state_n = HOLD;
            cause_n = acc ? CAUSE_EXT : CAUSE_SW;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        ur_n[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            rdy_n   = 1'b1;
                            state_n = RUN;
                        end else begin
                            gap_n   = STAGE_GAP;
                            idx_n   = '0;
                            state_n = RELEASE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap != '0) begin
                        gap_n = gap - 1'b1;
                    end else begin
                        idx_n     = nxt;
                        ur_n[nxt] = 1'b1;
                        gap_n     = STAGE_GAP;
                        if (nxt == IW'(NUM_CH - 1)) begin
                            rdy_n   = 1'b1;
                            state_n = RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.user_reset = ur;
    assign bus.ready      = rdy;
    assign bus.cause      = cause;
    assign bus.busy       = state != RUN;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed stimulus with a queue of expected output snapshots keyed by edge number
module tb_rst_sequencer;

    typedef struct {
        int         e;
        logic [2:0] ur;
        logic       rdy;
        logic [1:0] cs;
        logic       bsy;
        string      tag;
    } exp_t;

    logic clk;
    logic reset;
    int   ed;
    int   t0;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t x;

    rst_sequencer_if #(.NUM_CH(3)) bus ();

    rst_sequencer #(
        .NUM_CH     (3),
        .POR_CYCLES (21'd10),
        .SOFT_CYCLES(21'd5),
        .STAGE_GAP  (12'd3),
        .SYNC_STAGES(2),
        .FILT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute count of rising edges
    always @(posedge clk) ed <= ed + 1;

    // Pop every expectation due at this edge and compare on the falling edge
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].e <= ed) begin
            x = sb.pop_front();
            checks++;
            assert ({bus.user_reset, bus.ready, bus.cause, bus.busy} === {x.ur, x.rdy, x.cs, x.bsy})
            else begin
                errors++;
                $error("FAIL %s edge %0d observed ur=%b rdy=%b cause=%0d busy=%b expected ur=%b rdy=%b cause=%0d busy=%b",
                       x.tag, ed - t0, bus.user_reset, bus.ready, bus.cause, bus.busy, x.ur, x.rdy, x.cs, x.bsy);
            end
        end
    end

    function automatic void ex(int k, logic [2:0] u, logic r, logic [1:0] c, logic b, string t);
        sb.push_back('{t0 + k, u, r, c, b, t});
    endfunction

    task automatic go(int k);
        while (ed < t0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(string t);
        checks++;
        assert ({bus.user_reset, bus.ready, bus.cause, bus.busy} === 7'b000_0_00_1)
        else begin
            errors++;
            $error("FAIL %s observed ur=%b rdy=%b cause=%0d busy=%b expected ur=000 rdy=0 cause=0 busy=1",
                   t, bus.user_reset, bus.ready, bus.cause, bus.busy);
        end
    endtask

    task automatic power_up_expect(string p);
        ex(10, 3'b000, 0, 0, 1, {p, "_hold_end"});
        ex(11, 3'b001, 0, 0, 1, {p, "_ch0"});
        ex(14, 3'b001, 0, 0, 1, {p, "_gap"});
        ex(15, 3'b011, 0, 0, 1, {p, "_ch1"});
        ex(18, 3'b011, 0, 0, 1, {p, "_gap2"});
        ex(19, 3'b111, 1, 0, 0, {p, "_ready"});
        ex(25, 3'b111, 1, 0, 0, {p, "_run"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ed          = 0;
        t0          = 0;
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.ext_req = 1'b0;
        bus.sw_req  = 1'b0;
        #3;
        check_reset_state("reset_state");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        t0    = ed;
        power_up_expect("por");
        ex(31, 3'b000, 0, 2, 1, "sw_drop");
        ex(36, 3'b000, 0, 2, 1, "sw_hold");
        ex(37, 3'b001, 0, 2, 1, "sw_ch0");
        ex(44, 3'b011, 0, 2, 1, "sw_ch1");
        ex(45, 3'b111, 1, 2, 0, "sw_ready");
        go(30);
        bus.sw_req = 1'b1;
        go(31);
        bus.sw_req = 1'b0;
        ex(52, 3'b111, 1, 2, 0, "ext_short_ignored");
        ex(56, 3'b111, 1, 2, 0, "ext_filtering");
        ex(57, 3'b000, 0, 1, 1, "ext_accept");
        ex(65, 3'b000, 0, 1, 1, "ext_held");
        ex(78, 3'b000, 0, 1, 1, "ext_hold_end");
        ex(79, 3'b001, 0, 1, 1, "ext_ch0");
        ex(83, 3'b011, 0, 1, 1, "ext_ch1");
        ex(87, 3'b111, 1, 1, 0, "ext_ready");
        go(46);
        bus.ext_req = 1'b1;
        go(49);
        bus.ext_req = 1'b0;
        go(50);
        bus.ext_req = 1'b1;
        go(70);
        bus.ext_req = 1'b0;
        ex(91, 3'b000, 0, 2, 1, "sw2_drop");
        ex(105, 3'b111, 1, 2, 0, "sw2_ready");
        ex(116, 3'b111, 1, 2, 0, "both_before");
        ex(117, 3'b000, 0, 1, 1, "both_ext_wins");
        ex(120, 3'b000, 0, 1, 1, "both_held");
        ex(126, 3'b001, 0, 1, 1, "both_ch0");
        ex(130, 3'b011, 0, 1, 1, "both_ch1");
        ex(132, 3'b000, 0, 2, 1, "rel_sw_drop");
        ex(137, 3'b000, 0, 2, 1, "rel_sw_hold");
        ex(138, 3'b001, 0, 2, 1, "rel_sw_ch0");
        ex(142, 3'b011, 0, 2, 1, "rel_sw_ch1");
        ex(146, 3'b111, 1, 2, 0, "rel_sw_ready");
        ex(151, 3'b000, 0, 2, 1, "sw3_drop");
        ex(162, 3'b011, 0, 2, 1, "pre_async");
        go(90);
        bus.sw_req = 1'b1;
        go(91);
        bus.sw_req = 1'b0;
        go(110);
        bus.ext_req = 1'b1;
        go(116);
        bus.sw_req = 1'b1;
        go(117);
        bus.sw_req  = 1'b0;
        bus.ext_req = 1'b0;
        go(131);
        bus.sw_req = 1'b1;
        go(132);
        bus.sw_req = 1'b0;
        go(150);
        bus.sw_req = 1'b1;
        go(151);
        bus.sw_req = 1'b0;
        go(163);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async_mid_release");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        t0    = ed;
        power_up_expect("repor");
        go(30);
        checks++;
        assert (sb.size() === 0)
        else begin
            errors++;
            $error("FAIL pending_expectations observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single-output power-on-reset counter.
- Generates NUM_CH staged "run" enables (1 = out of reset) for the console's sub-blocks: LCD, chip core, UART, and others.
- After power-up or a reset request, the block holds every channel for a programmable time, then releases the channels in index order, spaced STAGE_GAP+1 cycles apart.
- Adds two new reset sources beyond power-on:
  - a glitch-filtered external request (button or watchdog pin);
  - a synchronous software pulse.
- Reports the cause of the last reset.

Parameters:
- NUM_CH, 3, number of staged run outputs (>=1).
- CNT_W, 21, width of the hold counter.
- POR_CYCLES, 21'h17D796, hold time after power-on reset (0.062 s @ 25 MHz).
- SOFT_CYCLES, 21'h00FFFF, hold time after an external or software request.
- GAP_W, 12, width of the stage-gap counter.
- STAGE_GAP, 1024, idle cycles between successive channel releases.
- SYNC_STAGES, 2, synchroniser depth on ext_req (>=2).
- FILT_CYCLES, 16, consecutive synchronised-high cycles needed to accept ext_req (>=1).

Ports:
- clk  in  1  system clock (25 MHz on the board).
- reset  in  1  asynchronous, active-low reset; 0 forces the power-on state immediately.
- ext_req  in  1  asynchronous active-high reset request from a pin.
- sw_req  in  1  synchronous one-cycle soft-reset pulse from the core.
- user_reset  out  NUM_CH  per-channel run enable; 1 = channel running.
- ready  out  1  1 when all channels have been released.
- cause  out  2  last reset source: 0 = POR, 1 = EXT, 2 = SW.
- busy  out  1  1 while in HOLD or RELEASE.

Behaviour:
- While reset=0 (asynchronous):
  - state=HOLD, counter=POR_CYCLES, idx=0, gap=0;
  - user_reset=0, ready=0, cause=0, busy=1;
  - synchroniser and filter cleared.
- States: HOLD, RELEASE, RUN.
- HOLD:
  - counter decrements by 1 per cycle.
  - On the edge where counter==0: user_reset[0]<=1.
    - If NUM_CH==1: ready<=1 and go to RUN.
    - Otherwise: gap<=STAGE_GAP, idx<=0, go to RELEASE.
  - user_reset[0] therefore rises at edge POR_CYCLES+1 after reset deasserts.
- RELEASE:
  - If gap!=0, gap decrements.
  - When gap==0: idx<=idx+1, user_reset[idx+1]<=1, gap<=STAGE_GAP.
  - If idx+1==NUM_CH-1: ready<=1 and go to RUN in the same edge.
  - Channel k rises exactly k*(STAGE_GAP+1) cycles after channel 0.
  - Once released, a channel stays high until the next reset event.
- RUN: all outputs stable; busy=0.
- Reset event = accepted ext request, or sw_req==1, in any state. Effect on the next edge:
  - user_reset<=0 (all channels simultaneously), ready<=0;
  - counter<=SOFT_CYCLES, state<=HOLD;
  - cause<=1 for ext, else 2.
  - If ext and sw coincide: EXT wins and cause=1.
- An event during HOLD or RELEASE restarts the hold at SOFT_CYCLES; every channel already released drops.
- ext filter:
  - ext_req passes through SYNC_STAGES flops.
  - A filter counter counts consecutive synchronised-1 cycles and resets to 0 on any synchronised 0.
  - acc=1 while count>=FILT_CYCLES; the count saturates.
  - The first event fires SYNC_STAGES+FILT_CYCLES+1 edges after the pin rises.
  - While acc stays 1, the block stays in HOLD with counter reloaded every cycle. Release starts SOFT_CYCLES+1 edges after acc falls.
  - A pulse shorter than FILT_CYCLES synchronised cycles is ignored.
- cause keeps its value until the next event or async reset.
- Counter widths: POR_CYCLES and SOFT_CYCLES must fit in CNT_W, and STAGE_GAP must fit in GAP_W. Arithmetic is unsigned. Counters never wrap: HOLD exits on 0, and gap reloads on 0.
- Async reset asserted mid-RELEASE: all outputs drop in the same instant. After deassertion the full POR_CYCLES sequence runs again and cause=0.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum (HOLD, RELEASE, RUN);
  - cause encodings CAUSE_POR=2'd0, CAUSE_EXT=2'd1, CAUSE_SW=2'd2.
- One sub-module: rst_filter (parameters SYNC_STAGES and FILT_CYCLES; ports clk, reset, in, acc), containing the synchroniser plus the consecutive-cycle filter.
- The sequencing FSM, counters and output registers live in rst_sequencer.

Test Plan:
Bench parameters: NUM_CH=3, POR_CYCLES=10, SOFT_CYCLES=5, STAGE_GAP=3, SYNC_STAGES=2, FILT_CYCLES=4.
- Power-up: deassert reset at edge 0 -> user_reset = 3'b001 at edge 11, 3'b011 at edge 15, 3'b111 and ready=1 at edge 19; cause=0; busy=0 from edge 19.
- sw_req pulse at edge 30 -> user_reset=0, ready=0, cause=2 at edge 31; channel 0 rises at edge 37, channel 2 and ready at edge 45.
- ext_req high for 3 cycles in RUN -> no change; hold ext_req high for 20 cycles from edge 50 -> user_reset=0 and cause=1 at edge 57; release resumes SOFT_CYCLES+1 after the filter drops.
- Simultaneous sw_req and accepted ext in RUN -> cause=1; all channels drop on one edge.
- sw_req during RELEASE with user_reset=3'b011 -> both channels drop; new hold of SOFT_CYCLES; full staged sequence reruns.
- Assert reset mid-RELEASE -> outputs 0 immediately without a clock edge; after release, timing identical to the power-up case and cause=0.
